// File: rtl/gate_sched_pkg.sv
// Shared types and the bitwise evaluation function for the gate scheduler.
package gate_sched_pkg;

    localparam int unsigned GATE_MAX_W = 64;

    typedef enum logic [1:0] {
        OP_NOT = 2'd0,
        OP_AND = 2'd1,
        OP_OR  = 2'd2,
        OP_XOR = 2'd3
    } gate_op_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } slot_state_e;

    // Callers zero-extend operands to GATE_MAX_W and truncate the result to their width.
    function automatic logic [GATE_MAX_W-1:0] gate_eval(
        input gate_op_e              op,
        input logic [GATE_MAX_W-1:0] a,
        input logic [GATE_MAX_W-1:0] b
    );
        logic [GATE_MAX_W-1:0] r;
        case (op)
            OP_NOT:  r = ~a;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from last+1 upward (mod N), pointer moves only on a grant.
module rr_arbiter #(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic [IW-1:0] last;
    logic [31:0]   cand;
    logic          found;

    always_comb begin
        gnt     = '0;
        gnt_idx = last;
        found   = 1'b0;
        cand    = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = ({{(32-IW){1'b0}}, last} + k) % N;
            if (!found && req[cand]) begin
                found   = 1'b1;
                gnt_idx = IW'(cand);
            end
        end
        if (en && found) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last <= IW'(N - 1);
        end else if (en && |req) begin
            last <= gnt_idx;
        end
    end

endmodule

// File: rtl/gate_scheduler.sv
// Shares one bitwise logic unit among N_REQ requesters; one-entry tagged result register.
module gate_scheduler
    import gate_sched_pkg::*;
#(
    parameter  int unsigned N_REQ = 4,
    parameter  int unsigned W     = 8,
    localparam int unsigned IW    = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [2*N_REQ-1:0] req_op,
    input  logic [W*N_REQ-1:0] req_a,
    input  logic [W*N_REQ-1:0] req_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [W-1:0]       rsp_data,
    output logic [IW-1:0]      rsp_id
);

    slot_state_e   state, state_nxt;
    logic          can_issue;
    logic          arb_en;
    logic          accept;
    logic [IW-1:0] sel_idx;
    logic [1:0]    sel_op;
    logic [W-1:0]  sel_a;
    logic [W-1:0]  sel_b;

    assign rsp_valid = (state == ST_FULL);
    assign can_issue = !rsp_valid || rsp_ready;
    // Gating with rst keeps req_ready low during the reset cycle.
    assign arb_en    = can_issue && !rst;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .en      (arb_en),
        .gnt     (req_ready),
        .gnt_idx (sel_idx)
    );

    assign accept = |req_ready;
    assign sel_op = req_op[sel_idx*2 +: 2];
    assign sel_a  = req_a[sel_idx*W +: W];
    assign sel_b  = req_b[sel_idx*W +: W];

    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (accept) state_nxt = ST_FULL;
            ST_FULL: begin
                if (accept)         state_nxt = ST_FULL;
                else if (rsp_ready) state_nxt = ST_EMPTY;
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_data <= '0;
            rsp_id   <= '0;
        end else if (accept) begin
            rsp_data <= W'(gate_eval(gate_op_e'(sel_op), GATE_MAX_W'(sel_a), GATE_MAX_W'(sel_b)));
            rsp_id   <= sel_idx;
        end
    end

endmodule

// File: tb/tb_gate_scheduler.sv
// Directed and randomized checks of gate_scheduler with N_REQ=4, W=8.
module tb_gate_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [7:0]  req_op = '0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [7:0]  rsp_data;
    logic [1:0]  rsp_id;

    int n_cmp = 0;
    int n_bad = 0;

    logic [1:0] id_q[$];
    logic [7:0] data_q[$];

    gate_scheduler #(.N_REQ(4), .W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_eval(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            2'd0:    return ~a;
            2'd1:    return a & b;
            2'd2:    return a | b;
            default: return a ^ b;
        endcase
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        req_valid[i]      = v;
        req_op[i*2 +: 2]  = op;
        req_a[i*8 +: 8]   = a;
        req_b[i*8 +: 8]   = b;
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_reqs();
        rsp_ready = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            cyc();
            #1;
            n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
            n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", rsp_valid); end
            n_cmp++; if (rsp_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", rsp_data); end
            n_cmp++; if (rsp_id !== 2'd0) begin n_bad++; $display("FAIL reset_id: got %0d want 0", rsp_id); end
        end
        clear_reqs();
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_not_single();
        rsp_ready = 1'b1;
        set_req(2, 1'b1, 2'd0, 8'h0F, 8'h55);
        #1;
        n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL not_ready: got %b want 0100", req_ready); end
        cyc();
        set_req(2, 1'b0, 2'd0, 8'h00, 8'h00);
        #1;
        n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL not_valid: got %b want 1", rsp_valid); end
        n_cmp++; if (rsp_data !== 8'hF0) begin n_bad++; $display("FAIL not_data: got %h want f0", rsp_data); end
        n_cmp++; if (rsp_id !== 2'd2) begin n_bad++; $display("FAIL not_id: got %0d want 2", rsp_id); end
        cyc();
        #1;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL not_drain: got %b want 0", rsp_valid); end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_d[4] = '{8'h88, 8'hEE, 8'h66, 8'h33};
        do_reset();
        rsp_ready = 1'b1;
        set_req(0, 1'b1, 2'd1, 8'hCC, 8'hAA);
        set_req(1, 1'b1, 2'd2, 8'hCC, 8'hAA);
        set_req(2, 1'b1, 2'd3, 8'hCC, 8'hAA);
        set_req(3, 1'b1, 2'd0, 8'hCC, 8'hAA);
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL rr_first: got %b want 0001", req_ready); end
        for (int k = 0; k < 4; k++) begin
            cyc();
            set_req(k, 1'b0, 2'd0, 8'h00, 8'h00);
            #1;
            n_cmp++; if (rsp_data !== exp_d[k] || rsp_id !== 2'(k) || rsp_valid !== 1'b1) begin
                n_bad++; $display("FAIL rr_result%0d: got v=%b id=%0d d=%h want v=1 id=%0d d=%h", k, rsp_valid, rsp_id, rsp_data, k, exp_d[k]);
            end
            n_cmp++; if (req_ready !== ((k < 3) ? 4'(1 << (k + 1)) : 4'b0000)) begin
                n_bad++; $display("FAIL rr_grant%0d: got %b", k + 1, req_ready);
            end
        end
        cyc();
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        set_req(0, 1'b1, 2'd1, 8'hF0, 8'h3C);
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL bp_first: got %b want 0001", req_ready); end
        cyc();
        set_req(0, 1'b0, 2'd0, 8'h00, 8'h00);
        set_req(1, 1'b1, 2'd2, 8'h01, 8'h02);
        for (int c = 0; c < 5; c++) begin
            #1;
            n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL bp_ready%0d: got %b want 0000", c, req_ready); end
            n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h30 || rsp_id !== 2'd0) begin
                n_bad++; $display("FAIL bp_hold%0d: got v=%b id=%0d d=%h want v=1 id=0 d=30", c, rsp_valid, rsp_id, rsp_data);
            end
            cyc();
        end
        rsp_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL bp_release: got %b want 0010", req_ready); end
        cyc();
        set_req(1, 1'b0, 2'd0, 8'h00, 8'h00);
        #1;
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h03 || rsp_id !== 2'd1) begin
            n_bad++; $display("FAIL bp_reload: got v=%b id=%0d d=%h want v=1 id=1 d=03", rsp_valid, rsp_id, rsp_data);
        end
        cyc();
    endtask

    task automatic test_alternate();
        int gexp[9] = '{1, 3, 1, 3, 1, 3, 0, 1, 3};
        do_reset();
        rsp_ready = 1'b1;
        set_req(1, 1'b1, 2'd3, 8'h10, 8'h00);
        set_req(3, 1'b1, 2'd3, 8'h30, 8'h00);
        for (int k = 0; k < 9; k++) begin
            if (k == 5) set_req(0, 1'b1, 2'd3, 8'h00, 8'h00);
            #1;
            n_cmp++; if (req_ready !== 4'(1 << gexp[k])) begin n_bad++; $display("FAIL alt_grant%0d: got %b want idx %0d", k, req_ready, gexp[k]); end
            if (k > 0) begin
                n_cmp++; if (rsp_id !== 2'(gexp[k-1])) begin n_bad++; $display("FAIL alt_id%0d: got %0d want %0d", k, rsp_id, gexp[k-1]); end
            end
            cyc();
        end
    endtask

    task automatic test_reset_midop();
        rsp_ready = 1'b0;
        #1;
        n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL mid_full: got %b want 1", rsp_valid); end
        rst = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL mid_ready_rst: got %b want 0000", req_ready); end
        cyc();
        #1;
        n_cmp++; if (rsp_valid !== 1'b0 || rsp_data !== 8'h00 || rsp_id !== 2'd0) begin
            n_bad++; $display("FAIL mid_cleared: got v=%b id=%0d d=%h want v=0 id=0 d=00", rsp_valid, rsp_id, rsp_data);
        end
        n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL mid_ready_rst2: got %b want 0000", req_ready); end
        rst = 1'b0;
        rsp_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL mid_first: got %b want 0001", req_ready); end
        cyc();
        #1;
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin n_bad++; $display("FAIL mid_rsp: got v=%b id=%0d want v=1 id=0", rsp_valid, rsp_id); end
        clear_reqs();
        cyc();
    endtask

    task automatic test_random();
        logic [3:0] acc;
        logic       exp_any;
        logic [1:0] got_id;
        logic [7:0] got_d;
        int         idx;
        int         wait_cnt[4] = '{0, 0, 0, 0};
        do_reset();
        rsp_ready = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            #1;
            acc = req_valid & req_ready;
            n_cmp++; if ((req_ready & ~req_valid) != 4'b0000 || (req_ready & (req_ready - 4'd1)) != 4'b0000) begin
                n_bad++; $display("FAIL rnd_onehot c=%0d: ready=%b valid=%b", c, req_ready, req_valid);
            end
            exp_any = (!rsp_valid || rsp_ready) && (|req_valid);
            n_cmp++; if ((|req_ready) !== exp_any) begin n_bad++; $display("FAIL rnd_issue c=%0d: got %b want %b", c, |req_ready, exp_any); end
            n_cmp++; if (rsp_valid !== (id_q.size() != 0)) begin
                n_bad++; $display("FAIL rnd_valid c=%0d: got %b want %b", c, rsp_valid, id_q.size() != 0);
            end
            if (rsp_valid && rsp_ready && id_q.size() != 0) begin
                got_id = id_q.pop_front();
                got_d  = data_q.pop_front();
                n_cmp++; if (rsp_id !== got_id || rsp_data !== got_d) begin
                    n_bad++; $display("FAIL rnd_rsp c=%0d: got id=%0d d=%h want id=%0d d=%h", c, rsp_id, rsp_data, got_id, got_d);
                end
            end
            if (acc != 4'b0000) begin
                idx = 0;
                for (int i = 0; i < 4; i++) if (acc[i]) idx = i;
                id_q.push_back(2'(idx));
                data_q.push_back(ref_eval(req_op[idx*2 +: 2], req_a[idx*8 +: 8], req_b[idx*8 +: 8]));
            end
            for (int i = 0; i < 4; i++) begin
                if (!req_valid[i] || acc[i]) begin
                    wait_cnt[i] = 0;
                end else if (acc != 4'b0000) begin
                    wait_cnt[i]++;
                    n_cmp++; if (wait_cnt[i] > 3) begin n_bad++; $display("FAIL rnd_starve c=%0d: req %0d waited %0d want <=3", c, i, wait_cnt[i]); end
                end
            end
            cyc();
            for (int i = 0; i < 4; i++) begin
                if (acc[i] || !req_valid[i]) begin
                    set_req(i, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        clear_reqs();
        rsp_ready = 1'b1;
        #1;
        if (rsp_valid && id_q.size() != 0) begin
            got_id = id_q.pop_front();
            got_d  = data_q.pop_front();
            n_cmp++; if (rsp_id !== got_id || rsp_data !== got_d) begin
                n_bad++; $display("FAIL rnd_last: got id=%0d d=%h want id=%0d d=%h", rsp_id, rsp_data, got_id, got_d);
            end
        end
        cyc();
        #1;
        n_cmp++; if (rsp_valid !== 1'b0 || id_q.size() != 0) begin
            n_bad++; $display("FAIL rnd_drain: got v=%b pending=%0d want v=0 pending=0", rsp_valid, id_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_not_single();
        test_round_robin();
        test_backpressure();
        test_alternate();
        test_reset_midop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gate_scheduler.md
# gate_scheduler

Round-robin scheduler sharing one bitwise logic unit (NOT/AND/OR/XOR) among `N_REQ` requesters. Each requester presents operands and an opcode over a valid/ready handshake. The scheduler grants at most one request per cycle, evaluates it in the shared unit and holds the tagged result in a one-entry output register until the consumer accepts it. It sits between the requester-side control logic and the result sink, and is the only path into the shared gate unit.

## Interface
- `N_REQ`, 4, number of requesters (2..16)
- `W`, 8, operand/result width in bits
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous reset, active-high
- `req_valid`  in  N_REQ  per-requester request valid
- `req_ready`  out  N_REQ  per-requester accept; one-hot or zero
- `req_op`  in  N_REQ×2  opcode per requester: 0 NOT a, 1 AND, 2 OR, 3 XOR
- `req_a`  in  N_REQ×W  operand a per requester
- `req_b`  in  N_REQ×W  operand b per requester; ignored for NOT
- `rsp_valid`  out  1  result valid
- `rsp_ready`  in  1  consumer accepts result
- `rsp_data`  out  W  result
- `rsp_id`  out  $clog2(N_REQ)  index of the requester that produced `rsp_data`

## Operation
- Request i is accepted in a cycle when `req_valid[i] && req_ready[i]`. Response is accepted when `rsp_valid && rsp_ready`.
- `can_issue = !rsp_valid || rsp_ready`. Acceptance is allowed into an empty slot, or into a slot that is draining in the same cycle.
- When `can_issue` is high, `req_ready` is one-hot on the winner among the asserted `req_valid` bits. Otherwise `req_ready` is all zero.
- `req_ready` depends combinationally on `req_valid` and `rsp_ready`. Requesters must not make `req_valid` depend on `req_ready`.
- Round-robin order:
  - Pointer `last` holds the most recently granted index.
  - Search order is `last+1, last+2, …`, wrapping modulo `N_REQ`.
  - `last` updates only on an actual acceptance.
- Output register FSM:
  - States are EMPTY (`rsp_valid`=0) and FULL (`rsp_valid`=1).
  - EMPTY→FULL on acceptance.
  - FULL→EMPTY on response accept with no new acceptance.
  - FULL→FULL when a response accept and a new acceptance occur in the same cycle; the register is reloaded.
  - FULL with `rsp_ready`=0: `rsp_data` and `rsp_id` hold stable.
- Arithmetic: bitwise only, width `W`, no carry. NOT uses `req_a` only.
- A requester must hold `req_valid`, `req_op`, `req_a` and `req_b` stable until accepted. The scheduler does not drop or reorder a held request.

## Timing
- Latency: acceptance in cycle t gives `rsp_valid`=1 with the result in cycle t+1.
- Throughput: 1 result per cycle while `rsp_ready`=1.
- Reset values:
  - `rsp_valid`=0
  - `rsp_data`=0
  - `rsp_id`=0
  - `last`=`N_REQ`-1, so requester 0 has top priority after reset
  - `req_ready`=0 during the reset cycle
- Reset mid-operation: a held result is discarded without handshake. A request offered during reset is not accepted.
- No `req_valid` asserted: no acceptance, `last` unchanged.
- Back-pressure: with `rsp_valid`=1 and `rsp_ready`=0, all `req_ready`=0.
- Fairness: a continuously asserted request is granted within `N_REQ` acceptances.

## Structure
- Package `gate_sched_pkg` holds:
  - enum `gate_op_e` {OP_NOT=0, OP_AND=1, OP_OR=2, OP_XOR=3}
  - function `gate_eval(op, a, b)`
- Sub-module `rr_arbiter`:
  - Parameters: `N`.
  - Inputs: `clk`, `rst`, `req[N]`, `en`.
  - Outputs: `gnt[N]` (one-hot), `gnt_idx`.
  - Owns `last`, which updates only when `en && |req`.
- Top level contains the operand mux, the `gate_eval` call and the output register/FSM.

## Test plan
1. Reset, then only `req_valid[2]`, op NOT, a=8'h0F → next cycle `rsp_valid`=1, `rsp_data`=8'hF0, `rsp_id`=2.
2. All four valid, ops AND/OR/XOR/NOT, a=8'hCC, b=8'hAA, `rsp_ready`=1 → grants 0,1,2,3 on consecutive cycles. Results in order: 8'h88, 8'hEE, 8'h66, 8'h33.
3. `rsp_ready`=0 for 5 cycles with FULL → `req_ready`=0 throughout. `rsp_data`/`rsp_id` stable. Raising `rsp_ready` drains the slot and accepts the next request in the same cycle.
4. Requesters 1 and 3 always valid → grants strictly alternate 1,3,1,3. Adding requester 0 later → order continues 1,3,0,1,… with `last` respected.
5. Assert `rst` while FULL with a pending request → next cycle `rsp_valid`=0 and `req_ready`=0 during reset. First grant after reset goes to requester 0.
6. Randomized valid/ready over 10k cycles against a scoreboard → every accepted request yields exactly one result with the correct id and data. Starvation is never longer than 4 acceptances.
